// File: rtl/acia_rx_if.sv
// Receive-side bus between acia_rx and the ACIA register logic: received byte,
// completion strobe, error flags and busy indication.
interface acia_rx_if;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_busy;

    modport master (output rx_dat, output rx_stb, output rx_ferr, output rx_perr, output rx_busy);
    modport slave  (input  rx_dat, input  rx_stb, input  rx_ferr, input  rx_perr, input  rx_busy);
endinterface

// File: rtl/acia_rx.sv
// ACIA serial receiver: async 8N1 (8E1 when ACIA_RX_PARITY_EN is defined), LSB first,
// symbol timing from a pclk-gated down-counter shared in scheme with the transmitter.
module acia_rx #(
    parameter int SCW     = 9,
    parameter int SYM_CNT = 417
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     pclk,
    input  logic     rx_serial,
    acia_rx_if.master bus
);

    localparam logic [SCW-1:0] RELOAD = SCW'(SYM_CNT);
    localparam logic [SCW-1:0] HALF   = SCW'(SYM_CNT >> 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           sync1_q, sync2_q;
    logic [7:0]     dat_q, dat_d;
    logic           stb_q, stb_d;
    logic           ferr_q, ferr_d;
    logic           perr_q, perr_d;
    logic           rxs;
    logic           cnt_zero;

    assign rxs      = sync2_q;
    assign cnt_zero = (cnt_q == '0);

    // Synchronizer runs on every clk edge; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            dat_q     <= '0;
            stb_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            dat_q     <= dat_d;
            stb_q     <= stb_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        if (pclk) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = HALF;
                    end
                end
                START: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!rxs) begin
                        state_d   = DATA;
                        cnt_d     = RELOAD;
                        bit_cnt_d = 4'd8;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        shift_d   = {rxs, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        cnt_d     = RELOAD;
                        if (bit_cnt_q == 4'd1) begin
`ifdef ACIA_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef ACIA_RX_PARITY_EN
                PARITY: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        par_d   = rxs;
                        cnt_d   = RELOAD;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                        cnt_d   = RELOAD;
                        state_d = rxs ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stb_d  = pclk && (state_q == STOP) && cnt_zero;
        dat_d  = dat_q;
        ferr_d = ferr_q;
        perr_d = perr_q;
        if (stb_d) begin
            dat_d  = shift_q;
            ferr_d = ~rxs;
`ifdef ACIA_RX_PARITY_EN
            perr_d = (^shift_q) ^ par_q;
`else
            perr_d = 1'b0;
`endif
        end
    end

    assign bus.rx_dat  = dat_q;
    assign bus.rx_stb  = stb_q;
    assign bus.rx_ferr = ferr_q;
    assign bus.rx_perr = perr_q;
    assign bus.rx_busy = (state_q != IDLE);

endmodule
